// File: rtl/isu_crdt_arb.sv
// Credit-based round-robin arbiter sharing the ISU request port between LOAD, STORE and WAE.
// Optional sticky credit-overflow flag and report enabled by ISU_CRDT_OVF_CHK_EN.
module isu_crdt_arb #(
  parameter int NUM_CH   = 3,
  parameter int CRDT_MAX = 16,
  parameter int CRDT_W   = 5,
  parameter int ID_W     = 5,
  parameter int OFF_W    = 1,
  parameter int WBUF_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*3-1:0]        req_op,
  input  logic [NUM_CH*ID_W-1:0]     req_id,
  input  logic [NUM_CH*OFF_W-1:0]    req_offset,
  input  logic [NUM_CH*WBUF_W-1:0]   req_wbuf_id,
  input  logic [NUM_CH-1:0]          crdt_rtn,
  output logic                       isu_valid,
  input  logic                       isu_ready,
  output logic [NUM_CH-1:0]          isu_channel_1hot_id,
  output logic [2:0]                 isu_op,
  output logic [ID_W-1:0]            isu_id,
  output logic [OFF_W-1:0]           isu_offset,
  output logic [WBUF_W-1:0]          isu_wbuf_id,
  output logic [NUM_CH*CRDT_W-1:0]   crdt_avail,
  output logic                       crdt_err
);

  logic [1:0]        rr_ptr;
  logic [CRDT_W-1:0] credit [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic [1:0]        gnt_idx;
  logic              gnt_any;
  logic              load_en;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return 2'(s);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign elig[i] = req_valid[i] && (credit[i] != '0);
    assign crdt_avail[i*CRDT_W +: CRDT_W] = credit[i];
  end

  assign load_en = !isu_valid || isu_ready;

  // Scan from the rr pointer upward with wrap; first eligible channel wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_any && load_en && !rst && elig[rr_idx(rr_ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(rr_ptr, k);
      end
    end
    gnt = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;
  end

  assign req_ready = gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr              <= '0;
      isu_valid           <= 1'b0;
      isu_channel_1hot_id <= '0;
      isu_op              <= '0;
      isu_id              <= '0;
      isu_offset          <= '0;
      isu_wbuf_id         <= '0;
    end else if (gnt_any) begin
      rr_ptr              <= rr_idx(gnt_idx, 1);
      isu_valid           <= 1'b1;
      isu_channel_1hot_id <= gnt;
      isu_op              <= req_op[int'(gnt_idx)*3 +: 3];
      isu_id              <= req_id[int'(gnt_idx)*ID_W +: ID_W];
      isu_offset          <= req_offset[int'(gnt_idx)*OFF_W +: OFF_W];
      isu_wbuf_id         <= req_wbuf_id[int'(gnt_idx)*WBUF_W +: WBUF_W];
    end else if (isu_ready) begin
      isu_valid <= 1'b0;
    end
  end

  // Grant and return in the same cycle cancel; a return at full credit saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) credit[i] <= CRDT_W'(CRDT_MAX);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt[i] && !crdt_rtn[i])
          credit[i] <= credit[i] - CRDT_W'(1);
        else if (!gnt[i] && crdt_rtn[i] && (credit[i] != CRDT_W'(CRDT_MAX)))
          credit[i] <= credit[i] + CRDT_W'(1);
      end
    end
  end

`ifdef ISU_CRDT_OVF_CHK_EN
  logic [NUM_CH-1:0] ovf;

  always_comb begin
    ovf = '0;
    for (int i = 0; i < NUM_CH; i++)
      ovf[i] = crdt_rtn[i] && !gnt[i] && (credit[i] == CRDT_W'(CRDT_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       crdt_err <= 1'b0;
    else if (|ovf) crdt_err <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && !crdt_err) begin
      for (int i = 0; i < NUM_CH; i++)
        assert (!ovf[i]) else $warning("isu_crdt_arb: credit overflow on channel %0d", i);
    end
  end
`endif
`else
  assign crdt_err = 1'b0;
`endif

endmodule

// File: tb/tb_isu_crdt_arb.sv
// Scoreboard bench for isu_crdt_arb: directed scenarios plus randomized traffic vs a reference model.
module tb_isu_crdt_arb;
  localparam int CRDT_W = 5;
  localparam int CRDT_MAX = 16;
  localparam logic [2:0] CACHE_OP_WAE = 3'd5;
`ifdef ISU_CRDT_OVF_CHK_EN
  localparam bit OVF_CHK = 1'b1;
`else
  localparam bit OVF_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0, req_ready, crdt_rtn = '0;
  logic [8:0]  req_op = '0;
  logic [14:0] req_id = '0;
  logic [2:0]  req_offset = '0;
  logic [20:0] req_wbuf_id = '0;
  logic        isu_valid, isu_ready = 1'b0, crdt_err;
  logic [2:0]  isu_channel_1hot_id, isu_op;
  logic [4:0]  isu_id;
  logic [0:0]  isu_offset;
  logic [6:0]  isu_wbuf_id;
  logic [14:0] crdt_avail;

  isu_crdt_arb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_id(req_id), .req_offset(req_offset), .req_wbuf_id(req_wbuf_id),
    .crdt_rtn(crdt_rtn),
    .isu_valid(isu_valid), .isu_ready(isu_ready),
    .isu_channel_1hot_id(isu_channel_1hot_id), .isu_op(isu_op), .isu_id(isu_id),
    .isu_offset(isu_offset), .isu_wbuf_id(isu_wbuf_id),
    .crdt_avail(crdt_avail), .crdt_err(crdt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ch;
    logic [2:0] op;
    logic [4:0] id;
    logic       off;
    logic [6:0] wbuf;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_cr[3];
  int m_rr;
  int m_valid;
  int m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT presents a request, it must match the oldest expected grant.
  always @(negedge clk) begin
    exp_t act;
    if (!rst && isu_valid) begin
      act = '{ch: isu_channel_1hot_id, op: isu_op, id: isu_id, off: isu_offset[0], wbuf: isu_wbuf_id};
      if (exp_q.size() == 0) begin
        chk("isu_unexpected", 32'(act), 32'hFFFF_FFFF);
      end else begin
        chk("isu_payload", 32'(act), 32'(exp_q[0]));
        if (isu_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cr[i] = CRDT_MAX;
    m_rr = 0;
    m_valid = 0;
    m_err = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic [2:0] v, input logic rdy, input logic [2:0] rtn, input bit rand_pl);
    int g;
    bit ld;
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("crdt_avail%0d", i), 32'(crdt_avail[i*CRDT_W +: CRDT_W]), 32'(m_cr[i]));
    chk("crdt_err", 32'(crdt_err), 32'(m_err));
    chk("isu_valid", 32'(isu_valid), 32'(m_valid));
    if (rand_pl) begin
      req_op      = 9'($urandom);
      req_id      = 15'($urandom);
      req_offset  = 3'($urandom);
      req_wbuf_id = 21'($urandom);
    end
    req_valid = v;
    isu_ready = rdy;
    crdt_rtn  = rtn;
    #1;
    ld = (m_valid == 0) || rdy;
    g = -1;
    if (ld) begin
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_rr + k) % 3;
        if (g < 0 && v[c] && m_cr[c] > 0) g = c;
      end
    end
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      e.ch   = 3'(1 << g);
      e.op   = req_op[3*g +: 3];
      e.id   = req_id[5*g +: 5];
      e.off  = req_offset[g];
      e.wbuf = req_wbuf_id[7*g +: 7];
      exp_q.push_back(e);
      m_rr = (g + 1) % 3;
    end
    for (int i = 0; i < 3; i++) begin
      int taken;
      taken = (g == i) ? 1 : 0;
      if (rtn[i] && taken == 0 && m_cr[i] == CRDT_MAX) begin
        if (OVF_CHK) m_err = 1;
      end else begin
        m_cr[i] = m_cr[i] - taken + int'(rtn[i]);
      end
    end
    if (g >= 0) m_valid = 1;
    else if (rdy) m_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_isu_valid", 32'(isu_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_crdt", 32'(crdt_avail), {17'd0, 5'd16, 5'd16, 5'd16});
    chk("rst_crdt_err", 32'(crdt_err), 32'd0);
    model_reset();
    req_valid = '0;
    crdt_rtn  = '0;
    isu_ready = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    do_reset();

    // Round robin with all channels requesting
    repeat (4) step(3'b111, 1'b1, 3'b000, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b1);
    chk("rr_crdt", 32'(crdt_avail), {17'd0, 5'd15, 5'd15, 5'd14});

    // STORE exhaustion, then one returned credit buys one grant
    do_reset();
    repeat (18) step(3'b010, 1'b1, 3'b000, 1'b1);
    chk("store_empty", 32'(crdt_avail[9:5]), 32'd0);
    step(3'b010, 1'b1, 3'b010, 1'b1);
    repeat (3) step(3'b010, 1'b1, 3'b000, 1'b1);
    chk("store_one_more", 32'(crdt_avail[9:5]), 32'd0);

    // WAE held under back-pressure
    do_reset();
    req_op = {CACHE_OP_WAE, 6'd0};
    req_id = {5'b11101, 10'd0};
    req_offset = '0;
    req_wbuf_id = {7'd7, 14'd0};
    step(3'b100, 1'b1, 3'b000, 1'b0);
    repeat (5) step(3'b111, 1'b0, 3'b000, 1'b0);
    step(3'b000, 1'b1, 3'b000, 1'b0);
    step(3'b000, 1'b1, 3'b000, 1'b0);

    // LOAD grant and return cancel at credit 3
    do_reset();
    repeat (13) step(3'b001, 1'b1, 3'b000, 1'b1);
    step(3'b001, 1'b1, 3'b001, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b1);
    chk("load_c3", 32'(crdt_avail[4:0]), 32'd3);

    // Return at full credit saturates
    do_reset();
    step(3'b000, 1'b1, 3'b100, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b1);
    chk("ovf_sat", 32'(crdt_avail[14:10]), 32'd16);
    chk("ovf_err", 32'(crdt_err), 32'(OVF_CHK));

    // Reset while a request is in flight
    do_reset();
    repeat (3) step(3'b110, 1'b0, 3'b000, 1'b1);
    do_reset();
    step(3'b111, 1'b1, 3'b000, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b1);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [2:0] v, r;
      v = 3'($urandom);
      for (int i = 0; i < 3; i++) r[i] = ($urandom_range(0, 5) == 0);
      step(v, ($urandom_range(0, 3) != 0), r, 1'b1);
    end
    repeat (3) step(3'b000, 1'b1, 3'b000, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
